poli_ctrl_bank: RTL and testbench

- Parametrised multi-channel successor to the single POLI test-structure control register.
- Holds per-channel orientation and enable configuration for NCH test structures.
  - Staged through an addressed write port into shadow registers.
  - Applied atomically on a commit strobe.
- After the structures settle, captures per-channel status into readable registers.
- Sits between the host/scan-side register bus and the test-structure array.

---
 rtl/poli_ctrl_bank_pkg.sv | 18 +
 rtl/poli_ctrl_bank_settle_fsm.sv | 61 ++++++
 rtl/poli_ctrl_bank.sv | 91 +++++++++
 tb/tb_poli_ctrl_bank.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/poli_ctrl_bank_pkg.sv
// Shared types and address-region constants for the POLI control bank.
package POLI_types_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, SETTLE, CAPTURE} poli_state_t;

    localparam int ORIENT_W_DEF = 2;

    typedef struct packed {
        logic                    en;
        logic [ORIENT_W_DEF-1:0] orient;
    } chan_cfg_t;

    // Region bases in units of NCH: config at 0, status at NCH, control word at 2*NCH.
    localparam int CFG_BASE  = 0;
    localparam int STAT_BASE = 1;
    localparam int CTRL_OFS  = 2;

endpackage

// File: rtl/poli_ctrl_bank_settle_fsm.sv
// Apply/settle/capture sequencer: owns state, settle counter, busy/done and the strobes.
module poli_settle_fsm
    import POLI_types_pkg::*;
#(
    parameter int SETTLE_CYC = 3
) (
    input  logic CLK,
    input  logic nRST,
    input  logic commit,
    output logic busy,
    output logic done,
    output logic apply,
    output logic capture
);

    localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYC == 0) ? 8'd0 : 8'(SETTLE_CYC - 1);

    poli_state_t state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        busy       = (state_reg != IDLE);
        done       = 1'b0;
        apply      = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (commit) state_next = APPLY;
            end
            APPLY: begin
                apply      = 1'b1;
                cnt_next   = SETTLE_LOAD;
                state_next = (SETTLE_CYC == 0) ? CAPTURE : SETTLE;
            end
            SETTLE: begin
                // counter loaded with SETTLE_CYC-1, so the zero check yields SETTLE_CYC cycles
                if (cnt_reg == 8'd0) state_next = CAPTURE;
                else                 cnt_next   = cnt_reg - 8'd1;
            end
            CAPTURE: begin
                done       = 1'b1;
                capture    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/poli_ctrl_bank.sv
// Multi-channel POLI control bank: shadow/active config registers, status capture and bus decode.
module poli_ctrl_bank
    import POLI_types_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int ORIENT_W   = 2,
    parameter int STAT_W     = 4,
    parameter int SETTLE_CYC = 3,
    parameter int ADDR_W     = $clog2(2*NCH+1)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    input  logic                     commit,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [NCH*ORIENT_W-1:0]  orient,
    output logic [NCH-1:0]           chan_en,
    input  logic [NCH*STAT_W-1:0]    status_in,
    output logic [NCH*STAT_W-1:0]    status_q
);

    localparam int CFG_W     = ORIENT_W + 1;
    localparam int STAT_LO   = STAT_BASE * NCH;
    localparam int CTRL_ADDR = CTRL_OFS * NCH;

    logic [CFG_W-1:0]  shadow_reg [NCH];
    logic [CFG_W-1:0]  active_reg [NCH];
    logic [STAT_W-1:0] stat_reg   [NCH];
    logic [NCH-1:0]    cfg_hit;
    logic              apply, capture, ctrl_wr, err_set;

    poli_settle_fsm #(.SETTLE_CYC(SETTLE_CYC)) u_fsm (
        .CLK     (CLK),
        .nRST    (nRST),
        .commit  (commit),
        .busy    (busy),
        .done    (done),
        .apply   (apply),
        .capture (capture)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            assign cfg_hit[gi] = wen && (addr == ADDR_W'(CFG_BASE + gi));

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    shadow_reg[gi] <= '0;
                    active_reg[gi] <= '0;
                    stat_reg[gi]   <= '0;
                end else begin
                    if (cfg_hit[gi] && !busy) shadow_reg[gi] <= wdata[CFG_W-1:0];
                    if (apply)                active_reg[gi] <= shadow_reg[gi];
                    if (capture)
                        stat_reg[gi] <= active_reg[gi][ORIENT_W] ?
                                        status_in[gi*STAT_W +: STAT_W] : '0;
                end
            end

            assign orient[gi*ORIENT_W +: ORIENT_W] = active_reg[gi][ORIENT_W-1:0];
            assign chan_en[gi]                     = active_reg[gi][ORIENT_W];
            assign status_q[gi*STAT_W +: STAT_W]   = stat_reg[gi];
        end
    endgenerate

    assign ctrl_wr = wen && (addr == ADDR_W'(CTRL_ADDR));
    assign err_set = ((|cfg_hit) || commit) && busy;

    // a new error in the same cycle as a clear leaves the flag set
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                    err <= 1'b0;
        else if (err_set)             err <= 1'b1;
        else if (ctrl_wr && wdata[0]) err <= 1'b0;
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (addr == ADDR_W'(CFG_BASE + i))  rdata = 32'(shadow_reg[i]);
            if (addr == ADDR_W'(STAT_LO + i))   rdata = 32'(stat_reg[i]);
        end
        if (addr == ADDR_W'(CTRL_ADDR)) rdata = {30'b0, err, busy};
    end

endmodule

// File: tb/tb_poli_ctrl_bank.sv
// Directed bench for poli_ctrl_bank: register-access vector table plus apply/settle/capture sequences.
module tb_poli_ctrl_bank;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        wen, commit;
    logic [3:0]  addr;
    logic [31:0] wdata, rdata;
    logic        busy, done, err;
    logic [7:0]  orient;
    logic [3:0]  chan_en;
    logic [15:0] status_in, status_q;

    logic        b_wen, b_commit;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic        b_busy, b_done, b_err;
    logic [7:0]  b_orient;
    logic [3:0]  b_chan_en;
    logic [15:0] b_status_in, b_status_q;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    poli_ctrl_bank dut (
        .CLK(CLK), .nRST(nRST), .wen(wen), .addr(addr), .wdata(wdata), .rdata(rdata),
        .commit(commit), .busy(busy), .done(done), .err(err), .orient(orient),
        .chan_en(chan_en), .status_in(status_in), .status_q(status_q)
    );

    poli_ctrl_bank #(.SETTLE_CYC(0)) dut0 (
        .CLK(CLK), .nRST(nRST), .wen(b_wen), .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata),
        .commit(b_commit), .busy(b_busy), .done(b_done), .err(b_err), .orient(b_orient),
        .chan_en(b_chan_en), .status_in(b_status_in), .status_q(b_status_q)
    );

    typedef struct {
        logic        wen;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd0, 32'h6,  32'h6};
        vecs[1] = '{1'b1, 4'd2, 32'h5,  32'h5};
        vecs[2] = '{1'b1, 4'd1, 32'hFF, 32'h7};
        vecs[3] = '{1'b1, 4'd1, 32'h0,  32'h0};
        vecs[4] = '{1'b1, 4'd4, 32'h9,  32'h0};
        vecs[5] = '{1'b1, 4'd9, 32'h3,  32'h0};
        vecs[6] = '{1'b0, 4'd8, 32'h0,  32'h0};
        vecs[7] = '{1'b1, 4'd3, 32'h8,  32'h0};
        vecs[8] = '{1'b0, 4'd15, 32'h0, 32'h0};

        wen = 0; commit = 0; addr = 0; wdata = 0; status_in = 16'hABCD;
        b_wen = 0; b_commit = 0; b_addr = 0; b_wdata = 0; b_status_in = 16'h0003;

        // reset
        nRST = 1'b0;
        tick(); tick();
        nRST = 1'b1;
        addr = 4'd8;
        #1;
        check("rst_orient", 32'(orient), 32'h0);
        check("rst_chan_en", 32'(chan_en), 32'h0);
        check("rst_status_q", 32'(status_q), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rd_ctrl", rdata, 32'h0);

        // register access table
        for (int i = 0; i < 9; i++) begin
            wen = vecs[i].wen; addr = vecs[i].addr; wdata = vecs[i].wdata;
            tick();
            wen = 1'b0;
            #1;
            $display("vec %0d wen=%0d addr=%0d wdata=0x%0h rdata=0x%0h", i, vecs[i].wen,
                     vecs[i].addr, vecs[i].wdata, rdata);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end
        check("vec_err", 32'(err), 32'h0);

        // apply and capture, latency
        commit = 1'b1;
        tick();                       // edge 0
        commit = 1'b0;
        check("ap_busy_e0", 32'(busy), 32'h1);
        check("ap_orient_e0", 32'(orient), 32'h0);
        tick();                       // edge 1
        check("ap_orient_e1", 32'(orient), 32'h12);
        check("ap_chan_en_e1", 32'(chan_en), 32'h5);
        check("ap_done_e1", 32'(done), 32'h0);
        tick();
        check("ap_done_e2", 32'(done), 32'h0);
        tick();
        check("ap_done_e3", 32'(done), 32'h0);
        tick();
        check("ap_done_e4", 32'(done), 32'h1);
        check("ap_stat_e4", 32'(status_q), 32'h0);
        tick();
        check("ap_done_e5", 32'(done), 32'h0);
        check("ap_busy_e5", 32'(busy), 32'h0);
        check("ap_stat_e5", 32'(status_q), 32'h0B0D);
        addr = 4'd4; #1; check("ap_rd4", rdata, 32'hD);
        addr = 4'd5; #1; check("ap_rd5", rdata, 32'h0);
        addr = 4'd6; #1; check("ap_rd6", rdata, 32'hB);
        $display("apply: orient=0x%0h chan_en=0x%0h status_q=0x%0h", orient, chan_en, status_q);

        // protocol errors while busy
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();                       // now in SETTLE
        bus_write(4'd1, 32'h7);
        addr = 4'd1; #1;
        check("be_err_wr", 32'(err), 32'h1);
        check("be_shadow1", rdata, 32'h0);
        wen = 1'b1; addr = 4'd8; wdata = 32'h1; commit = 1'b1;
        tick();
        wen = 1'b0; commit = 1'b0;
        check("be_set_wins", 32'(err), 32'h1);
        wait_idle();
        addr = 4'd8; #1;
        check("be_rd_ctrl", rdata, 32'h2);
        bus_write(4'd8, 32'h1);
        #1;
        check("be_err_clr", 32'(err), 32'h0);
        check("be_rd_ctrl2", rdata, 32'h0);
        $display("busy errors: err=%0d", err);

        // back-to-back commit in the first IDLE cycle
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wait_idle();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("b2b_busy", 32'(busy), 32'h1);
        check("b2b_err", 32'(err), 32'h0);
        wait_idle();
        $display("back-to-back: err=%0d", err);

        // same-cycle write and commit
        wen = 1'b1; addr = 4'd3; wdata = 32'h7; commit = 1'b1;
        tick();
        wen = 1'b0; commit = 1'b0;
        tick();
        check("sc_chan_en3", 32'(chan_en[3]), 32'h1);
        check("sc_orient3", 32'(orient[7:6]), 32'h3);
        check("sc_err", 32'(err), 32'h0);
        wait_idle();
        $display("same-cycle: orient=0x%0h chan_en=0x%0h", orient, chan_en);

        // zero-settle instance
        b_wen = 1'b1; b_addr = 4'd0; b_wdata = 32'h4;
        tick();
        b_wen = 1'b0;
        b_commit = 1'b1;
        tick();                       // edge 0
        b_commit = 1'b0;
        check("z_done_e0", 32'(b_done), 32'h0);
        tick();                       // edge 1
        check("z_done_e1", 32'(b_done), 32'h1);
        check("z_chan_en_e1", 32'(b_chan_en), 32'h1);
        check("z_stat_e1", 32'(b_status_q), 32'h0);
        tick();                       // edge 2
        check("z_done_e2", 32'(b_done), 32'h0);
        check("z_stat_e2", 32'(b_status_q), 32'h0003);
        check("z_busy_e2", 32'(b_busy), 32'h0);
        $display("zero-settle: status_q=0x%0h", b_status_q);

        // reset mid-sequence
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        bus_write(4'd1, 32'h7);       // raises err while in SETTLE
        #2;
        nRST = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_orient", 32'(orient), 32'h0);
        check("mr_chan_en", 32'(chan_en), 32'h0);
        check("mr_status_q", 32'(status_q), 32'h0);
        check("mr_err", 32'(err), 32'h0);
        check("mr_done", 32'(done), 32'h0);
        tick();
        nRST = 1'b1;
        addr = 4'd3; #1;
        check("mr_shadow3", rdata, 32'h0);
        bus_write(4'd0, 32'h6);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        check("mr_orient_e1", 32'(orient), 32'h2);
        check("mr_chan_en_e1", 32'(chan_en), 32'h1);
        tick(); tick(); tick();
        check("mr_done_e4", 32'(done), 32'h1);
        tick();
        check("mr_stat_e5", 32'(status_q), 32'h000D);
        $display("post-reset apply: orient=0x%0h status_q=0x%0h", orient, status_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
